// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared widths and FSM encoding for the FIR output BCD converter.
package fir_pkg;

    localparam int W_YOUT   = 12;
    localparam int N_DIGITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Sample/result bundle between a binary producer and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int W_BIN    = fir_pkg::W_YOUT,
    parameter int N_DIGITS = fir_pkg::N_DIGITS
) ();

    // Handshake: a sample transfers on a rising edge where i_valid and o_ready are both 1;
    // i_valid while o_ready=0 is dropped, and o_valid is a single-cycle pulse with no back-pressure.
    logic                      i_valid;
    logic [W_BIN-1:0]          i_bin;
    logic                      o_ready;
    logic                      o_valid;
    logic [4*N_DIGITS-1:0]     o_bcd;
    logic [N_DIGITS-1:0]       o_lz_mask;
    fir_pkg::state_t           dbg_state;

    modport master (
        output i_valid, i_bin,
        input  o_ready, o_valid, o_bcd, o_lz_mask, dbg_state
    );

    modport slave (
        input  i_valid, i_bin,
        output o_ready, o_valid, o_bcd, o_lz_mask, dbg_state
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the next shift.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock, with leading-zero mask.
module bin_to_bcd_seq #(
    parameter int W_BIN    = fir_pkg::W_YOUT,
    parameter int N_DIGITS = fir_pkg::N_DIGITS
) (
    input logic             i_clk,
    input logic             i_rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int CW = $clog2(W_BIN + 1);
    localparam int BW = 4 * N_DIGITS;
    localparam longint DEC_SPAN = longint'(10) ** N_DIGITS;
    localparam longint BIN_SPAN = longint'(1) << W_BIN;

    if (DEC_SPAN <= BIN_SPAN) begin : g_range_err
        $error("bin_to_bcd_seq: N_DIGITS too small for W_BIN");
    end

    fir_pkg::state_t state_q, state_d;

    logic [CW-1:0]       cnt_q;
    logic [W_BIN-1:0]    bin_q;
    logic [BW-1:0]       acc_q;
    logic [BW-1:0]       acc_adj;
    logic [BW+W_BIN-1:0] shifted;
    logic [BW-1:0]       acc_shift;
    logic [W_BIN-1:0]    bin_shift;
    logic [BW-1:0]       bcd_q;
    logic [N_DIGITS-1:0] mask_q, mask_d;
    logic                valid_q;
    logic                accept;
    logic                last_shift;
    logic                zero_above;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (acc_q[4*g +: 4]),
            .o_digit (acc_adj[4*g +: 4])
        );
    end

    assign shifted    = {acc_adj, bin_q} << 1;
    assign acc_shift  = shifted[W_BIN +: BW];
    assign bin_shift  = shifted[W_BIN-1:0];
    assign accept     = bus.i_valid && (state_q == fir_pkg::IDLE);
    assign last_shift = (state_q == fir_pkg::SHIFT) && (cnt_q == CW'(W_BIN - 1));

    // A digit is blanked only if it and every digit above it are zero; units always shows.
    always_comb begin
        mask_d     = '0;
        zero_above = 1'b1;
        for (int d = N_DIGITS - 1; d > 0; d--) begin
            zero_above = zero_above && (acc_shift[4*d +: 4] == 4'd0);
            mask_d[d]  = zero_above;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= fir_pkg::IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            fir_pkg::IDLE:  if (accept)     state_d = fir_pkg::SHIFT;
            fir_pkg::SHIFT: if (last_shift) state_d = fir_pkg::IDLE;
            default:                        state_d = fir_pkg::IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            mask_q  <= {{(N_DIGITS-1){1'b1}}, 1'b0};
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                bin_q <= bus.i_bin;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == fir_pkg::SHIFT) begin
                acc_q <= acc_shift;
                bin_q <= bin_shift;
                cnt_q <= cnt_q + CW'(1);
                if (last_shift) begin
                    bcd_q   <= acc_shift;
                    mask_q  <= mask_d;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_ready   = (state_q == fir_pkg::IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_bcd     = bcd_q;
    assign bus.o_lz_mask = mask_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter W_BIN, default 12, meaning binary input width (FIR filter output Yout width).
REQ-002 The block SHALL have parameter N_DIGITS, default 4, meaning number of BCD digits produced.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: i_bin holds a sample to convert.
REQ-006 The block SHALL have port i_bin, input, W_BIN bits: unsigned binary value, e.g. the filter's Yout.
REQ-007 The block SHALL have port o_ready, output, 1 bit: the block accepts a new sample this cycle.
REQ-008 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a new result in o_bcd.
REQ-009 The block SHALL have port o_bcd, output, 4*N_DIGITS bits: packed BCD result, digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port o_lz_mask, output, N_DIGITS bits: bit d set means digit d is a leading zero to blank.

Function
REQ-011 The block SHALL implement sequential shift-add-3 (double dabble) conversion: one shift per clock.
REQ-012 The FSM SHALL have states IDLE and SHIFT; o_ready SHALL be 1 exactly when the state is IDLE.
REQ-013 Acceptance SHALL occur on a rising edge where i_valid=1 and o_ready=1: i_bin is captured, the BCD accumulator is cleared, the shift counter is zeroed, and IDLE goes to SHIFT.
REQ-014 In SHIFT, each edge SHALL add 3 to every accumulator digit >=5, then shift {accumulator, binary} left by 1 bit.
REQ-015 On the edge completing shift number W_BIN, the block SHALL load o_bcd and o_lz_mask, set o_valid=1, and return to IDLE.
REQ-016 Latency: for accept edge k, o_valid SHALL be high in the cycle following edge k+W_BIN (12 cycles for the default).
REQ-017 o_valid SHALL stay high for exactly one cycle; o_ready SHALL be high in that same cycle.
REQ-018 Peak throughput SHALL be one conversion per W_BIN+1 cycles, with a back-to-back accept allowed in the o_valid cycle.
REQ-019 o_bcd and o_lz_mask SHALL hold the last result until the next completion; the display multiplexer reads them at any time.
REQ-020 i_valid while in SHIFT SHALL be ignored; no queuing, and the in-flight conversion is unaffected.
REQ-021 o_lz_mask bit d SHALL be 1 when digit d and all higher digits are zero, with d>0; digit 0 is never masked, so value 0 shows "0".
REQ-022 All arithmetic SHALL be unsigned; digit adjust SHALL be 4-bit, and no digit SHALL exceed 9 after completion.
REQ-023 Elaboration SHALL fail if 10**N_DIGITS <= 2**W_BIN, i.e. if the digits cannot hold the maximum input.

Reset
REQ-024 Asserting i_rst SHALL immediately force state IDLE, shift counter 0, and accumulator 0.
REQ-025 Asserting i_rst SHALL force outputs to o_bcd=0, o_valid=0, o_ready=1 and o_lz_mask={N_DIGITS-1 ones, 0}.
REQ-026 Reset mid-conversion SHALL discard the conversion; no o_valid pulse SHALL follow for it.
REQ-027 i_valid=1 on the first edge after reset deassertion SHALL be accepted normally.

Structure
REQ-028 Package fir_pkg SHALL hold W_YOUT=12, N_DIGITS=4, and the FSM state enum; defaults SHALL reference these.
REQ-029 Sub-module bcd_digit_adj SHALL be a combinational 4-bit add-3-if->=5 function, instantiated N_DIGITS times via generate.
REQ-030 The shift counter SHALL be $clog2(W_BIN+1) bits wide.
REQ-031 The block SHALL contain no latches and no derived clocks.

Verification
REQ-032 The bench SHALL check: accept i_bin=0 -> 12 cycles later o_valid pulse, o_bcd=0x0000, o_lz_mask=4'b1110.
REQ-033 The bench SHALL check: i_bin=4095 -> o_bcd=0x4095, o_lz_mask=4'b0000; i_bin=1000 -> 0x1000; i_bin=7 -> 0x0007, mask 4'b1110.
REQ-034 The bench SHALL check: i_valid held high with inputs 123 then 456 -> accepts exactly 13 cycles apart, results 0x0123 then 0x0456, one pulse each.
REQ-035 The bench SHALL check: i_valid pulsed with 999 while busy converting 42 -> only 0x0042 is produced, and o_ready stays 0 throughout SHIFT.
REQ-036 The bench SHALL check: i_rst asserted at shift 6 of 4095 -> outputs reset immediately and no o_valid; next accept of 58 -> 0x0058.
REQ-037 The bench SHALL check: an exhaustive sweep 0..4095 against a reference model of decimal digits -> all match, and o_valid count equals 4096.
